// File: rtl/lfsr_tap_search_pkg.sv
// Shared LFSR definitions: controller state encoding, preamble default and
// the 7-bit LFSR step used by both the tap search and the decrypt datapath.
package lfsr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEED,
    CHECK,
    DONE
  } state_e;

  localparam logic [7:0] PRE_CHAR_DEFAULT = 8'h5F;

  function automatic logic [6:0] lfsr7_next(input logic [6:0] state,
                                            input logic [6:0] taps);
    return {state[5:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_tap_search.sv
// Recovers the LFSR tap-table index that encrypted a message by capturing the
// preamble and replaying the 7-bit LFSR for each table entry in turn.
module lfsr_tap_search
  import lfsr_pkg::*;
#(
  parameter int unsigned NUM_TAPS = 9,
  parameter int unsigned PRE_LEN  = 4,
  parameter logic [7:0]  PRE_CHAR = PRE_CHAR_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic [7:0] In_data,
  input  logic       In_valid,
  output logic       In_ready,
  output logic [7:0] LutAddr,
  input  logic [7:0] LutTarget,
  output logic       Busy,
  output logic       Done,
  output logic       Found,
  output logic [7:0] TapIdx
);

  localparam int unsigned IW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int unsigned KW = $clog2(PRE_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_TAPS - 1);
  localparam logic [KW-1:0] LAST_K   = KW'(PRE_LEN - 1);

  state_e        state_q, state_d;
  logic [6:0]    exp_q [PRE_LEN];
  logic [KW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d;
  logic [6:0]    lfsr_q, lfsr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] tap_q, tap_d;
  logic          found_q, found_d;

  logic [6:0]    lfsr_nxt;
  logic          hit;
  logic          accept;
  logic          unused_bits;

  assign unused_bits = ^{In_data[7], LutTarget[7]};

  always_comb begin
    lfsr_nxt = lfsr7_next(lfsr_q, LutTarget[6:0]);
    hit      = (lfsr_nxt == exp_q[k_q]);
    accept   = (state_q == LOAD) && In_valid;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      lfsr_q  <= '0;
      idx_q   <= '0;
      tap_q   <= '0;
      found_q <= 1'b0;
      for (int unsigned i = 0; i < PRE_LEN; i++) exp_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      tap_q   <= tap_d;
      found_q <= found_d;
      // Buffer holds the expected LFSR states (byte ^ PRE_CHAR, bits 6:0)
      // rather than raw bytes; only those bits ever reach a compare.
      if (accept) exp_q[cnt_q] <= In_data[6:0] ^ PRE_CHAR[6:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Start) state_d = LOAD;
      LOAD:    if (accept && (cnt_q == LAST_K)) state_d = SEED;
      SEED:    state_d = CHECK;
      CHECK: begin
        if (hit) begin
          if (k_q == LAST_K) state_d = DONE;
        end else begin
          state_d = (idx_q == LAST_IDX) ? DONE : SEED;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    k_d     = k_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    tap_d   = tap_q;
    found_d = found_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          cnt_d   = '0;
          idx_d   = '0;
          tap_d   = '0;
          found_d = 1'b0;
        end
      end
      LOAD: if (accept) cnt_d = cnt_q + 1'b1;
      SEED: begin
        lfsr_d = exp_q[0];
        k_d    = KW'(1);
      end
      CHECK: begin
        if (hit) begin
          if (k_q == LAST_K) begin
            found_d = 1'b1;
            tap_d   = idx_q;
          end else begin
            lfsr_d = lfsr_nxt;
            k_d    = k_q + 1'b1;
          end
        end else if (idx_q != LAST_IDX) begin
          idx_d = idx_q + 1'b1;
        end else begin
          found_d = 1'b0;
          tap_d   = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    In_ready = (state_q == LOAD);
    Busy     = (state_q != IDLE);
    Done     = (state_q == DONE);
    Found    = found_q;
    TapIdx   = 8'(tap_q);
    LutAddr  = 8'(idx_q);
  end

endmodule
